cla_nibble_serial_adder: RTL

//  Multi-cycle WIDTH-bit adder. Consumes operands and carry-in, processes one 4-bit digit per clock

---
 rtl/cla_nibble_serial_adder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder
//   Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead digit per clock,
//   least-significant digit first. Valid/ready handshake on operands and result.
//   Optional macro CLA_SERIAL_SUB_EN adds the i_sub port (a - b when i_sub=1).
//   WIDTH must be a multiple of 4 and at least 8.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;        // operand A, shifted right one digit per CALC cycle
  logic [WIDTH-1:0] b_q;        // operand B (possibly inverted), shifted likewise
  logic [WIDTH-1:0] s_q;
  logic             carry_q;    // carry into the current digit
  logic [CNT_W-1:0] cnt_q;      // index of the digit being processed
  logic             co_q;
  logic             ovf_q;
  logic             i_ready_q;
  logic             o_valid_q;

  // Operand conditioning at capture: subtract stores ~b and forces carry-in to 1
  logic [WIDTH-1:0] b_d;
  logic             ci_d;

  // Select the B operand and carry-in that get captured in IDLE
  always_comb begin
    b_d  = b;
    ci_d = ci;
`ifdef CLA_SERIAL_SUB_EN
    if (i_sub) begin
      b_d  = ~b;
      ci_d = 1'b1;
    end
`endif
  end

  // 4-bit lookahead slice; the operand registers always present the active digit in bits [3:0]
  logic [3:0] g_d;
  logic [3:0] p_d;
  logic [4:0] c_d;
  logic [3:0] sum_digit_d;

  // Generate/propagate and flat lookahead carries seeded by the carry register
  always_comb begin
    g_d    = a_q[3:0] & b_q[3:0];
    p_d    = a_q[3:0] | b_q[3:0];
    c_d[0] = carry_q;
    c_d[1] = g_d[0] | (p_d[0] & c_d[0]);
    c_d[2] = g_d[1] | (p_d[1] & g_d[0]) | (p_d[1] & p_d[0] & c_d[0]);
    c_d[3] = g_d[2] | (p_d[2] & g_d[1]) | (p_d[2] & p_d[1] & g_d[0])
           | (p_d[2] & p_d[1] & p_d[0] & c_d[0]);
    c_d[4] = g_d[3] | (p_d[3] & g_d[2]) | (p_d[3] & p_d[2] & g_d[1])
           | (p_d[3] & p_d[2] & p_d[1] & g_d[0])
           | (p_d[3] & p_d[2] & p_d[1] & p_d[0] & c_d[0]);
    sum_digit_d = a_q[3:0] ^ b_q[3:0] ^ c_d[3:0];
  end

  // Control FSM with registered handshake outputs and the digit datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      co_q      <= 1'b0;
      ovf_q     <= 1'b0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid && i_ready_q) begin
            a_q       <= a;
            b_q       <= b_d;
            carry_q   <= ci_d;
            cnt_q     <= '0;
            i_ready_q <= 1'b0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          s_q[{cnt_q, 2'b00} +: 4] <= sum_digit_d;
          carry_q <= c_d[4];
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          if (cnt_q == LAST_DIGIT) begin
            // Carry into the MSB is c3 of the top digit; carry out is c4
            co_q      <= c_d[4];
            ovf_q     <= c_d[3] ^ c_d[4];
            o_valid_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // Result is held until taken; operands are never accepted in this state
          if (o_ready) begin
            o_valid_q <= 1'b0;
            i_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          i_ready_q <= 1'b1;
          o_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign s       = s_q;
  assign co      = co_q;
  assign ovf     = ovf_q;

endmodule
